// File: rtl/mcs_trace_pkg.sv
// Shared types for the MCS trace capture buffer.
// Record layout is {pc, instr, flags}, flags in the low nibble.
package mcs_trace_pkg;

  localparam int TRACE_REC_W = 68;
  localparam int FLAGS_LSB   = 0;
  localparam int FLAGS_W     = 4;
  localparam int INSTR_LSB   = 4;
  localparam int INSTR_W     = 32;
  localparam int PC_LSB      = 36;
  localparam int PC_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } cap_state_e;

  function automatic logic [TRACE_REC_W-1:0] pack_rec(
    input logic [PC_W-1:0]    pc,
    input logic [INSTR_W-1:0] instr,
    input logic [FLAGS_W-1:0] flags
  );
    return {pc, instr, flags};
  endfunction

endpackage

// File: rtl/mcs_trace_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Shaped so synthesis maps it onto block RAM.
module trace_ram
  import mcs_trace_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [TRACE_REC_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [TRACE_REC_W-1:0] rdata
);

  logic [TRACE_REC_W-1:0] mem_q [DEPTH];
  logic [TRACE_REC_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mcs_trace_capture.sv
// MCS trace capture: circular history of retired instructions,
// frozen a fixed number of entries after a PC-match or forced trigger.
module mcs_trace_capture
  import mcs_trace_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int POST_TRIG = 128
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   tr_valid,
  input  logic [31:0]            tr_pc,
  input  logic [31:0]            tr_instr,
  input  logic [3:0]             tr_flags,
  input  logic                   tr_halted,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   force_trig,
  input  logic                   trig_en,
  input  logic [31:0]            trig_pc,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [TRACE_REC_W-1:0] rd_data,
  output logic                   armed,
  output logic                   triggered,
  output logic                   done,
  output logic [ADDR_W:0]        count
);

  localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] POST_LD = ADDR_W'(POST_TRIG);

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic              trig_q, trig_d;
  logic              armed_q, done_q;
  logic              we;
  logic              hit;
  logic [ADDR_W-1:0] rd_phys;

  assign hit = (trig_en && tr_valid && (tr_pc == trig_pc))
             || force_trig;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_d     = trig_q;
    we         = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d  = ST_ARMED;
            wr_ptr_d = '0;
            count_d  = '0;
            trig_d   = 1'b0;
          end
        end
        ST_ARMED: begin
          we = tr_valid;
          if (hit) begin
            state_d    = ST_POST;
            trig_d     = 1'b1;
            post_cnt_d = POST_LD;
          end
        end
        ST_POST: begin
          // An exhausted post counter stores nothing more.
          we = tr_valid && (post_cnt_q != '0);
          if (we) post_cnt_d = post_cnt_q - 1'b1;
          if ((post_cnt_q == '0) || tr_halted
              || (tr_valid && (post_cnt_q == ADDR_W'(1))))
            state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q != FULL) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_q     <= trig_d;
      armed_q    <= (state_d == ST_ARMED) || (state_d == ST_POST);
      done_q     <= (state_d == ST_DONE);
    end
  end

  // Once wrapped, the oldest entry sits at the write pointer.
  assign rd_phys = (count_q == FULL) ? (wr_ptr_q + rd_addr) : rd_addr;

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset_ (reset_),
    .we     (we),
    .waddr  (wr_ptr_q),
    .wdata  (pack_rec(tr_pc, tr_instr, tr_flags)),
    .raddr  (rd_phys),
    .rdata  (rd_data)
  );

  assign armed     = armed_q;
  assign triggered = trig_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mcs_trace_capture.sv
// Directed self-checking bench for mcs_trace_capture.
// Main DUT: DEPTH=16, POST_TRIG=4; second DUT: POST_TRIG=0.
module tb_mcs_trace_capture;

  logic        clk = 1'b0;
  logic        reset_;
  logic        tr_valid, tr_halted;
  logic [31:0] tr_pc, tr_instr, trig_pc;
  logic [3:0]  tr_flags;
  logic        arm, abort, force_trig, trig_en;
  logic [3:0]  rd_addr;

  logic [67:0] rd_data, rd_data0;
  logic        armed, triggered, done;
  logic        armed0, triggered0, done0;
  logic [4:0]  count, count0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mcs_trace_capture #(.DEPTH(16), .ADDR_W(4), .POST_TRIG(4)) u_dut (
    .clk(clk), .reset_(reset_), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_flags(tr_flags), .tr_halted(tr_halted),
    .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr),
    .rd_data(rd_data), .armed(armed), .triggered(triggered),
    .done(done), .count(count)
  );

  mcs_trace_capture #(.DEPTH(16), .ADDR_W(4), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .reset_(reset_), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_instr(tr_instr), .tr_flags(tr_flags), .tr_halted(tr_halted),
    .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr),
    .rd_data(rd_data0), .armed(armed0), .triggered(triggered0),
    .done(done0), .count(count0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] rec(input logic [31:0] pc);
    logic [3:0] f;
    f = pc[5:2];
    return {pc, pc ^ 32'hA5A5_0000, f};
  endfunction

  task automatic feed(input logic [31:0] pc);
    logic [67:0] r;
    r = rec(pc);
    tr_valid = 1'b1;
    tr_pc    = pc;
    tr_instr = r[35:4];
    tr_flags = r[3:0];
    step();
    tr_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    step();
    step();
    reset_ = 1'b1;
    step();
    checks++;
    if (armed !== 1'b0) begin
      fails++; $display("FAIL reset_armed: got %b want 0", armed);
    end
    checks++;
    if (triggered !== 1'b0) begin
      fails++; $display("FAIL reset_trig: got %b want 0", triggered);
    end
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (count !== 5'd0) begin
      fails++; $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if (rd_data !== 68'd0 || rd_data0 !== 68'd0) begin
      fails++;
      $display("FAIL reset_rd_data: got %h/%h want 0", rd_data, rd_data0);
    end
  endtask

  task automatic test_pc_trigger();
    trig_en = 1'b1;
    trig_pc = 32'h20;
    pulse_arm();
    checks++;
    if (armed !== 1'b1 || count !== 5'd0) begin
      fails++;
      $display("FAIL pc_armed: got armed=%b count=%0d want 1/0", armed, count);
    end
    for (int k = 0; k <= 12; k++) begin
      feed(32'(k * 4));
      if (k == 8) begin
        checks++;
        if (triggered !== 1'b1) begin
          fails++; $display("FAIL pc_trig: got %b want 1", triggered);
        end
      end
      if (k == 11) begin
        checks++;
        if (done !== 1'b0) begin
          fails++; $display("FAIL pc_early_done: got %b want 0", done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || armed !== 1'b0) begin
      fails++;
      $display("FAIL pc_done: got done=%b armed=%b want 1/0", done, armed);
    end
    feed(32'h34);
    checks++;
    if (count !== 5'd13) begin
      fails++; $display("FAIL pc_count: got %0d want 13", count);
    end
    for (int i = 0; i <= 12; i++) begin
      rd_addr = 4'(i);
      step();
      checks++;
      if (rd_data !== rec(32'(i * 4))) begin
        fails++;
        $display("FAIL pc_read[%0d]: got %h want %h",
                 i, rd_data, rec(32'(i * 4)));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int          addr   [3];
    trig_en   = 1'b1;
    trig_pc   = 32'h9C;
    addr[0]   = 0;  exp_pc[0] = 32'h70;
    addr[1]   = 5;  exp_pc[1] = 32'h84;
    addr[2]   = 15; exp_pc[2] = 32'hAC;
    pulse_arm();
    for (int k = 0; k < 44; k++) feed(32'(k * 4));
    checks++;
    if (done !== 1'b1 || count !== 5'd16) begin
      fails++;
      $display("FAIL wrap_done: got done=%b count=%0d want 1/16", done, count);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 4'(addr[i]);
      step();
      checks++;
      if (rd_data !== rec(exp_pc[i])) begin
        fails++;
        $display("FAIL wrap_read[%0d]: got %h want %h",
                 addr[i], rd_data, rec(exp_pc[i]));
      end
    end
  endtask

  task automatic test_force();
    trig_en = 1'b0;
    pulse_abort();
    pulse_arm();
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    checks++;
    if (triggered0 !== 1'b1 || done0 !== 1'b0) begin
      fails++;
      $display("FAIL force_post: got trig=%b done=%b want 1/0",
               triggered0, done0);
    end
    step();
    checks++;
    if (done0 !== 1'b1 || triggered0 !== 1'b1 || count0 !== 5'd0) begin
      fails++;
      $display("FAIL force_done: got done=%b trig=%b count=%0d want 1/1/0",
               done0, triggered0, count0);
    end
  endtask

  task automatic test_halt();
    trig_en = 1'b1;
    trig_pc = 32'h08;
    pulse_abort();
    pulse_arm();
    tr_halted = 1'b1;
    feed(32'h00);
    tr_halted = 1'b0;
    checks++;
    if (armed !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL halt_armed: got armed=%b done=%b want 1/0", armed, done);
    end
    feed(32'h04);
    feed(32'h08);
    feed(32'h0C);
    feed(32'h10);
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL halt_early: got %b want 0", done);
    end
    tr_halted = 1'b1;
    feed(32'h14);
    tr_halted = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 5'd6) begin
      fails++;
      $display("FAIL halt_done: got done=%b count=%0d want 1/6", done, count);
    end
    rd_addr = 4'd5;
    step();
    checks++;
    if (rd_data !== rec(32'h14)) begin
      fails++;
      $display("FAIL halt_read: got %h want %h", rd_data, rec(32'h14));
    end
  endtask

  task automatic test_races();
    trig_en = 1'b0;
    pulse_abort();
    pulse_arm();
    feed(32'h00);
    feed(32'h04);
    feed(32'h08);
    arm = 1'b1;
    feed(32'h0C);
    arm = 1'b0;
    checks++;
    if (count !== 5'd4 || armed !== 1'b1) begin
      fails++;
      $display("FAIL race_rearm: got count=%0d armed=%b want 4/1", count, armed);
    end
    arm   = 1'b1;
    abort = 1'b1;
    step();
    arm   = 1'b0;
    abort = 1'b0;
    checks++;
    if (armed !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL race_abort: got armed=%b done=%b want 0/0", armed, done);
    end
    pulse_arm();
    force_trig = 1'b1;
    feed(32'h100);
    force_trig = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      feed(32'(32'h100 + k * 4));
      step();
      step();
    end
    checks++;
    if (done !== 1'b0 || count !== 5'd4) begin
      fails++;
      $display("FAIL race_gap: got done=%b count=%0d want 0/4", done, count);
    end
    feed(32'h110);
    checks++;
    if (done !== 1'b1 || count !== 5'd5) begin
      fails++;
      $display("FAIL race_gap_done: got done=%b count=%0d want 1/5", done, count);
    end
  endtask

  task automatic test_reset_mid_post();
    trig_en = 1'b1;
    trig_pc = 32'h04;
    pulse_arm();
    feed(32'h00);
    feed(32'h04);
    feed(32'h08);
    feed(32'h0C);
    reset_ = 1'b0;
    #1;
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 ||
        count !== 5'd0 || rd_data !== 68'd0) begin
      fails++;
      $display("FAIL mid_reset: got a=%b t=%b d=%b c=%0d r=%h want all 0",
               armed, triggered, done, count, rd_data);
    end
    step();
    reset_ = 1'b1;
    step();
    trig_en = 1'b0;
    pulse_arm();
    checks++;
    if (armed !== 1'b1 || count !== 5'd0) begin
      fails++;
      $display("FAIL mid_rearm: got armed=%b count=%0d want 1/0", armed, count);
    end
    feed(32'h40);
    checks++;
    if (count !== 5'd1) begin
      fails++; $display("FAIL mid_count: got %0d want 1", count);
    end
  endtask

  initial begin
    reset_     = 1'b1;
    tr_valid   = 1'b0;
    tr_halted  = 1'b0;
    tr_pc      = '0;
    tr_instr   = '0;
    tr_flags   = '0;
    arm        = 1'b0;
    abort      = 1'b0;
    force_trig = 1'b0;
    trig_en    = 1'b0;
    trig_pc    = '0;
    rd_addr    = '0;
    test_reset();
    test_pc_trigger();
    test_wrap();
    test_force();
    test_halt();
    test_races();
    test_reset_mid_post();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
